// File: rtl/bbsn_pkg.sv
// Shared definitions for the Blum-Blum-Shub generator: FSM states and
// parameter defaults / legal values.
package bbsn_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC_M,
        S_CHECK,
        S_SQUARE,
        S_PUSH,
        S_WAIT
    } state_t;

    localparam int WIDTH_DEF      = 32;
    localparam int OUT_W_DEF      = 32;
    localparam int BPS_DEF        = 1;
    localparam int FIFO_DEPTH_DEF = 4;

    // Bit n set means n is a legal BPS value (1, 2 or 4).
    localparam int BPS_LEGAL_MASK = 'b10110;
    localparam int FIFO_DEPTH_MIN = 2;

endpackage

// File: rtl/bbsn_modmul.sv
// Serial modular multiplier: a*b mod m, MSB-first, one bit of a per cycle.
// One load cycle followed by MW bit cycles; requires b < m.
module bbsn_modmul #(
    parameter int MW = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [MW-1:0] a,
    input  logic [MW-1:0] b,
    input  logic [MW-1:0] m,
    output logic          busy,
    output logic          done,
    output logic [MW-1:0] result
);
    localparam int CW = $clog2(MW + 1);

    logic [MW-1:0] a_sh;
    logic [MW-1:0] b_r;
    logic [MW-1:0] m_r;
    logic [MW-1:0] acc;
    logic [CW-1:0] cnt;
    logic [MW+1:0] m_ext;
    logic [MW+1:0] sum;
    logic [MW+1:0] red1;

    // 2*acc + b < 3*m, so two conditional subtracts bring it back below m.
    always_comb begin
        m_ext  = {2'b00, m_r};
        sum    = {1'b0, acc, 1'b0} + (a_sh[MW-1] ? {2'b00, b_r} : '0);
        red1   = (sum >= m_ext) ? (sum - m_ext) : sum;
        result = (red1 >= m_ext) ? MW'(red1 - m_ext) : MW'(red1);
    end

    assign done = busy && (cnt == CW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            cnt  <= '0;
            a_sh <= '0;
            b_r  <= '0;
            m_r  <= '0;
            acc  <= '0;
        end else if (abort) begin
            busy <= 1'b0;
        end else if (start) begin
            a_sh <= a;
            b_r  <= b;
            m_r  <= m;
            acc  <= '0;
            cnt  <= CW'(MW);
            busy <= 1'b1;
        end else if (busy) begin
            acc  <= result;
            a_sh <= a_sh << 1;
            cnt  <= cnt - CW'(1);
            if (cnt == CW'(1))
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/bbsn_core.sv
// Blum-Blum-Shub random word generator: computes M = p*q, iterates x <= x^2 mod M,
// harvests BPS LSBs per squaring into words and buffers them in a small FIFO.
module bbsn_core
    import bbsn_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int OUT_W      = OUT_W_DEF,
    parameter int BPS        = BPS_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [WIDTH-1:0]   p_i,
    input  logic [WIDTH-1:0]   q_i,
    input  logic [2*WIDTH-1:0] seed_i,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic               keep_m_i,
    input  logic               use_xnext_i,
    input  logic               cont_i,
    output logic [2*WIDTH-1:0] m_o,
    output logic               m_valid_o,
    output logic [OUT_W-1:0]   rand_o,
    output logic               rand_valid_o,
    input  logic               rand_ready_i,
    output logic               busy_o,
    output logic               err_o
);
    localparam int MW    = 2 * WIDTH;
    localparam int WORDS = OUT_W / BPS;
    localparam int CW    = $clog2(WIDTH + 1);
    localparam int SW    = $clog2(WORDS + 1);
    localparam int AW    = $clog2(FIFO_DEPTH);

    state_t            state;
    state_t            state_nx;
    logic [WIDTH-1:0]  p_r;
    logic [WIDTH-1:0]  q_sh;
    logic [MW-1:0]     m_r;
    logic              m_valid;
    logic [MW-1:0]     seed_r;
    logic              usex_r;
    logic [MW-1:0]     x_r;
    logic [MW-1:0]     x0;
    logic              chk_bad;
    logic [CW-1:0]     calc_cnt;
    logic [SW-1:0]     sq_cnt;
    logic [OUT_W-1:0]  word;
    logic [OUT_W-1:0]  word_nx;
    logic              mm_start;
    logic              mm_busy;
    logic              mm_done;
    logic [MW-1:0]     mm_result;

    logic [OUT_W-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              full;
    logic              push;
    logic              pop;
    logic              after_full;

    bbsn_modmul #(.MW(MW)) u_modmul (
        .clk    (clk_i),
        .rst    (rst_i),
        .start  (mm_start),
        .abort  (stop_i),
        .a      (x_r),
        .b      (x_r),
        .m      (m_r),
        .busy   (mm_busy),
        .done   (mm_done),
        .result (mm_result)
    );

    assign m_o          = m_r;
    assign m_valid_o    = m_valid;
    assign rand_valid_o = (count != '0);
    assign rand_o       = mem[rd_ptr];
    assign full         = (count == (AW+1)'(FIFO_DEPTH));
    assign pop          = rand_valid_o && rand_ready_i;
    assign after_full   = pop ? full : (count == (AW+1)'(FIFO_DEPTH - 1));

    // New bits enter at the top so the first squaring ends up in bits [BPS-1:0].
    always_comb begin
        x0      = usex_r ? x_r : seed_r;
        chk_bad = (m_r < MW'(2)) || (x0 == '0) || (x0 >= m_r);
        word_nx = (word >> BPS) | (OUT_W'(mm_result[BPS-1:0]) << (OUT_W - BPS));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (start_i) state_nx = (keep_m_i && m_valid) ? S_CHECK : S_CALC_M;
            S_CALC_M: if (calc_cnt == CW'(WIDTH - 1)) state_nx = S_CHECK;
            S_CHECK:  state_nx = chk_bad ? S_IDLE : S_SQUARE;
            S_SQUARE: if (mm_done && sq_cnt == SW'(WORDS - 1)) state_nx = S_PUSH;
            S_PUSH: begin
                if (push) begin
                    if (!cont_i)
                        state_nx = S_IDLE;
                    else if (after_full)
                        state_nx = S_WAIT;
                    else
                        state_nx = S_SQUARE;
                end
            end
            S_WAIT:   if (!full) state_nx = S_SQUARE;
            default:  state_nx = S_IDLE;
        endcase
        if (stop_i)
            state_nx = S_IDLE;
    end

    // PUSH holds (rather than overflowing) if a one-shot finds the FIFO already full.
    always_comb begin
        busy_o   = (state != S_IDLE);
        err_o    = (state == S_CHECK) && chk_bad;
        mm_start = (state == S_SQUARE) && !mm_busy && !stop_i;
        push     = (state == S_PUSH) && !stop_i && (!full || pop);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            p_r      <= '0;
            q_sh     <= '0;
            m_r      <= '0;
            m_valid  <= 1'b0;
            seed_r   <= '0;
            usex_r   <= 1'b0;
            x_r      <= '0;
            calc_cnt <= '0;
            sq_cnt   <= '0;
            word     <= '0;
        end else if (stop_i) begin
            word   <= '0;
            sq_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        p_r    <= p_i;
                        q_sh   <= q_i;
                        seed_r <= seed_i;
                        usex_r <= use_xnext_i;
                        word   <= '0;
                        sq_cnt <= '0;
                        if (!(keep_m_i && m_valid)) begin
                            m_r      <= '0;
                            m_valid  <= 1'b0;
                            calc_cnt <= '0;
                        end
                    end
                end
                S_CALC_M: begin
                    m_r      <= (m_r << 1) + (q_sh[WIDTH-1] ? MW'(p_r) : '0);
                    q_sh     <= q_sh << 1;
                    calc_cnt <= calc_cnt + CW'(1);
                    if (calc_cnt == CW'(WIDTH - 1))
                        m_valid <= 1'b1;
                end
                S_CHECK: begin
                    if (!chk_bad)
                        x_r <= x0;
                end
                S_SQUARE: begin
                    if (mm_done) begin
                        x_r    <= mm_result;
                        word   <= word_nx;
                        sq_cnt <= sq_cnt + SW'(1);
                    end
                end
                S_PUSH: begin
                    if (push)
                        sq_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

    // Output word FIFO; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push)
            mem[wr_ptr] <= word;
    end

endmodule

// File: doc/bbsn_core.md
BBSN_CORE -- requirements
Module: bbsn_core

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, bit width of each of p and q; MW = 2*WIDTH is the modulus width.
REQ-002 SHALL provide parameter OUT_W, default 32, width of one output random word.
REQ-003 SHALL provide parameter BPS, default 1, LSBs harvested per squaring; legal values 1, 2 or 4, and BPS SHALL divide OUT_W.
REQ-004 SHALL provide parameter FIFO_DEPTH, default 4, output word buffer depth; power of two, at least 2.
REQ-005 clk_i  in  1  sole clock, rising edge.
REQ-006 rst_i  in  1  asynchronous, active-high reset.
REQ-007 p_i, q_i  in  WIDTH each  prime factors, sampled on accepted start.
REQ-008 seed_i  in  MW  initial state x0, sampled on accepted start.
REQ-009 start_i  in  1  single-cycle pulse; accepted only in IDLE.
REQ-010 stop_i  in  1  abort request; dominates start_i.
REQ-011 keep_m_i  in  1  reuse the stored modulus and skip CALC_M when m_valid_o=1.
REQ-012 use_xnext_i  in  1  continue from the stored x instead of seed_i.
REQ-013 cont_i  in  1  0 = one-shot (one word, then IDLE); 1 = run until stop_i.
REQ-014 m_o  out  MW  modulus p*q; m_valid_o  out  1  m_o is valid.
REQ-015 rand_o  out  OUT_W, rand_valid_o  out  1, rand_ready_i  in  1: output stream; FIFO head is presented on rand_o.
REQ-016 busy_o  out  1  state is not IDLE; err_o  out  1  one-cycle error pulse.

Function
REQ-017 The FSM SHALL have the states IDLE, CALC_M, CHECK, SQUARE, PUSH and WAIT.
- IDLE -> CALC_M on start, or IDLE -> CHECK on start when keep_m_i=1 and m_valid_o=1.
- CALC_M -> CHECK after WIDTH cycles.
- CHECK -> SQUARE, or CHECK -> IDLE with err.
- SQUARE -> SQUARE, or SQUARE -> PUSH when the word is complete.
- PUSH -> SQUARE (cont_i=1 and FIFO not full), WAIT (FIFO full), or IDLE (one-shot).
- WAIT -> SQUARE when the FIFO is not full.
REQ-018 CALC_M SHALL compute p*q by shift-add, one bit per cycle, in exactly WIDTH cycles; m_valid_o SHALL clear on entry to CALC_M and set on exit.
REQ-019 CHECK (1 cycle) SHALL pulse err_o and return to IDLE if M<2, x0==0, or x0>=M.
- x0 is the stored x when use_xnext_i=1, otherwise seed_i.
- The stored x and m_o SHALL be unchanged by an error.
REQ-020 Each squaring SHALL compute x <= x*x mod M in exactly MW+1 cycles (1 load cycle plus MW bit cycles).
REQ-021 After each squaring, the BPS LSBs of the new x SHALL be shifted into the word, the first squaring filling bits [BPS-1:0].
REQ-022 A word SHALL be complete after OUT_W/BPS squarings; PUSH (1 cycle) writes it to the FIFO.
REQ-023 FIFO handshake:
- A word transfers when rand_valid_o and rand_ready_i are both 1.
- rand_valid_o=1 iff the FIFO is non-empty.
- A simultaneous push and pop on a full FIFO SHALL be legal.
- Pointers SHALL wrap modulo FIFO_DEPTH.
REQ-024 stop_i SHALL take effect in any state: the next state is IDLE and a partial word is discarded.
- On stop_i, FIFO contents, m_o/m_valid_o and the x of the last completed squaring SHALL be kept.
REQ-025 While in WAIT, no squaring SHALL advance; x and the partial word SHALL be held.
REQ-026 All modular arithmetic SHALL be exact for any M < 2^MW, with intermediates at least MW+2 bits wide.

Reset
REQ-027 On rst_i, without waiting for a clock edge:
- the state SHALL be IDLE;
- x, m_o and the word register SHALL be 0;
- m_valid_o, rand_valid_o, busy_o and err_o SHALL be 0;
- the FIFO SHALL be empty.
REQ-028 rst_i asserted mid-operation SHALL abandon all work; no word SHALL be pushed afterwards.

Structure
REQ-029 The package bbsn_pkg SHALL hold the FSM state enum and the parameter defaults/legal-value constants.
REQ-030 The sub-module bbsn_modmul SHALL compute a*b mod M MSB-first, with at most two conditional subtracts per cycle, and SHALL have start/done ports.
REQ-031 The FIFO SHALL be implemented inside bbsn_core.

Verification
REQ-032 WIDTH=8, OUT_W=8, BPS=1; p=11, q=23, seed=3, cont=0, ready=1: m_o=253 after 8 cycles, one word rand_o=0x53, final x=234, then IDLE.
REQ-033 Same config, then start with keep_m_i=1 and use_xnext_i=1: no CALC_M cycles, m_valid_o stays 1, x continues from 234 (first squaring gives 108).
REQ-034 seed=0, then seed=253 (M=253): each run pulses err_o once, produces no word, and leaves busy_o=0 after CHECK.
REQ-035 cont=1, ready=0, FIFO_DEPTH=4: exactly 4 words pushed, then WAIT with x frozen; ready=1 for one cycle resumes, the next word matches the reference model.
REQ-036 stop_i asserted mid-SQUARE, then rst_i asserted mid-CALC_M: stop returns to IDLE with FIFO contents kept; reset clears all outputs immediately and the FIFO stays empty.
